uart_receiver: RTL

Serial-to-parallel UART receive stage for the memory-mapped peripheral block. Samples the asynchronous `rxd` line using the 16x oversampling tick from the baud-rate generator and deframes 8N1 characters. Holds each received byte with ready, overrun and framing-error status for the peripheral's UART data and control registers. A single-cycle acknowledge from the peripheral read path clears the status.

---
 rtl/uart_receiver_if.sv | 12 +
 rtl/uart_receiver.sv | 96 +++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// uart_receiver_if: received byte, status flags and read acknowledge between the UART receiver and the peripheral registers
interface uart_receiver_if;
  logic       rd_ack;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       rx_overrun;
  logic       rx_ferr;
  logic       rx_busy;
  modport master (input rd_ack, output rx_data, rx_valid, rx_ready, rx_overrun, rx_ferr, rx_busy);
  modport slave (output rd_ack, input rx_data, rx_valid, rx_ready, rx_overrun, rx_ferr, rx_busy);
endinterface

// File: rtl/uart_receiver.sv
// uart_receiver: 16x-oversampled 8N1 UART deframer with sticky ready/overrun/framing-error status
module uart_receiver #(
  parameter int OVERSAMPLE = 16
) (
  input logic             clk,
  input logic             reset,
  input logic             baud_tick,
  input logic             rxd,
  uart_receiver_if.master bus
);
  localparam int TW = $clog2(OVERSAMPLE);
  localparam logic [TW-1:0] HALF = TW'(OVERSAMPLE / 2 - 1);
  localparam logic [TW-1:0] LAST = TW'(OVERSAMPLE - 1);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_n;
  logic [TW-1:0] tick_cnt, tick_n;
  logic [2:0] bit_cnt, bit_n;
  logic [7:0] shift, shift_n;
  logic s1, s2, prev, fell, done_ok, done_err;
  assign fell = prev & ~s2;
  assign bus.rx_busy = state != IDLE;
  // two-flop synchronizer plus a history flop for falling-edge detection; idles high
  always_ff @(posedge clk or posedge reset)
    if (reset) {s1, s2, prev} <= 3'b111;
    else {s1, s2, prev} <= {rxd, s1, s2};
  // FSM state, tick/bit counters and shift register
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state    <= IDLE;
      tick_cnt <= '0;
      bit_cnt  <= '0;
      shift    <= '0;
    end else begin
      state    <= state_n;
      tick_cnt <= tick_n;
      bit_cnt  <= bit_n;
      shift    <= shift_n;
    end
  // next-state: counters advance only on baud ticks; samples taken mid start bit, then once per bit period
  always_comb begin
    state_n  = state;
    tick_n   = tick_cnt;
    bit_n    = bit_cnt;
    shift_n  = shift;
    done_ok  = 1'b0;
    done_err = 1'b0;
    case (state)
      IDLE: if (fell) begin
        state_n = START;
        tick_n  = '0;
      end
      START: if (baud_tick) begin
        tick_n = tick_cnt + 1'b1;
        if (tick_cnt == HALF) begin
          tick_n  = '0;
          bit_n   = '0;
          state_n = s2 ? IDLE : DATA;
        end
      end
      DATA: if (baud_tick) begin
        tick_n = tick_cnt + 1'b1;
        if (tick_cnt == LAST) begin
          tick_n  = '0;
          shift_n = {s2, shift[7:1]};
          bit_n   = bit_cnt + 3'd1;
          state_n = bit_cnt == 3'd7 ? STOP : DATA;
        end
      end
      STOP: if (baud_tick) begin
        tick_n = tick_cnt + 1'b1;
        if (tick_cnt == LAST) begin
          tick_n   = '0;
          state_n  = IDLE;
          done_ok  = s2;
          done_err = ~s2;
        end
      end
      default: state_n = IDLE;
    endcase
  end
  // status registers: frame completion takes priority over a coincident acknowledge
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      bus.rx_data    <= '0;
      bus.rx_valid   <= 1'b0;
      bus.rx_ready   <= 1'b0;
      bus.rx_overrun <= 1'b0;
      bus.rx_ferr    <= 1'b0;
    end else begin
      bus.rx_data    <= done_ok ? shift : bus.rx_data;
      bus.rx_valid   <= done_ok;
      bus.rx_ready   <= done_ok | (bus.rx_ready & ~bus.rd_ack);
      bus.rx_overrun <= (bus.rx_overrun | (done_ok & bus.rx_ready)) & ~bus.rd_ack;
      bus.rx_ferr    <= done_err | (bus.rx_ferr & ~bus.rd_ack);
    end
endmodule
